key_expansion: RTL and testbench
================================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of one key word; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports key_0_in..key_3_in  input  DATA_WIDTH each  128-bit cipher key words w0..w3; byte 0 of each word in bits 31:24.
REQ-005 SHALL have port key_load_in  input  1  single-cycle strobe; capture cipher key.
REQ-006 SHALL have port next_in  input  1  single-cycle strobe; advance to the next round key.
REQ-007 SHALL have ports key_0_out..key_3_out  output  DATA_WIDTH each  current round key words; drive the cipher round stage key inputs directly.
REQ-008 SHALL have port round_out  output  4  index (0..10) of the round key on key_*_out.
REQ-009 SHALL have port key_valid_out  output  1  high when key_*_out holds a valid round key.
REQ-010 SHALL have port key_last_out  output  1  high when round_out == 10 and key_valid_out is high.

Function
REQ-011 SHALL hold state in four registered key words, a 4-bit round register and a valid flag; all outputs SHALL be driven from registers only.
REQ-012 SHALL, on key_load_in high at a clock edge, load key_0_in..key_3_in into the key words, set round to 0 and set valid to 1.
REQ-013 SHALL, on next_in high with valid == 1 and round < 10 at a clock edge, replace the key with round key round+1 and increment round by 1.
REQ-014 SHALL compute the next key combinationally in one cycle:
  - t = SubWord(RotWord(w3)) XOR {Rcon[round+1], 24'h0}
  - w0' = w0 XOR t; w1' = w1 XOR w0'; w2' = w2 XOR w1'; w3' = w3 XOR w2'
REQ-015 SHALL use RotWord = {w3[23:0], w3[31:24]}, and SubWord SHALL apply the AES forward S-box to each of the 4 bytes.
REQ-016 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex), selected by the registered round value.
REQ-017 SHALL give next_in a latency of one cycle: the new key, round_out and key_last_out appear after the edge that samples next_in.
REQ-018 SHALL ignore next_in when round == 10, holding key, round and valid unchanged.
REQ-019 SHALL ignore next_in when valid == 0.
REQ-020 SHALL give key_load_in priority when key_load_in and next_in are high in the same cycle: load is performed and next_in is discarded.
REQ-021 SHALL honour key_load_in at any round, including mid-expansion; it restarts at round 0 with the new key.
REQ-022 SHALL hold all state when neither strobe is asserted.
REQ-023 SHALL be driven in lock-step with the cipher round counter: round_out SHALL equal the cipher's core count while the cipher is in its round state.

Reset
REQ-024 SHALL, while rst_n is low, immediately force key_0_out..key_3_out = 32'h0, round_out = 0, key_valid_out = 0 and key_last_out = 0, independent of clk.
REQ-025 SHALL, on reset assertion mid-expansion, abandon the expansion; after release valid stays 0 until the next key_load_in.

Verification
REQ-026 SHALL cover this scenario: load key 2b7e1516 28aed2a6 abf71588 09cf4f3c, then one next_in -> round_out = 1 and key = a0fafe17 88542cb1 23a33939 2a6c7605.
REQ-027 SHALL cover this scenario: same key, 10 consecutive next_in -> round_out = 10, key_last_out = 1, key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; an 11th next_in leaves the key unchanged.
REQ-028 SHALL cover this scenario: next_in after reset with no load -> key_valid_out stays 0 and key_*_out stays 0.
REQ-029 SHALL cover this scenario: key_load_in and next_in together at round 5 -> round_out = 0 and key_*_out equals the new key_*_in.
REQ-030 SHALL cover this scenario: rst_n pulsed low between clock edges at round 7 -> all outputs 0 immediately; reload followed by 10 next_in reproduces the REQ-027 values.
REQ-031 SHALL cover this scenario: all-zero key with 10 next_in -> round 1 key = 62636363 62636363 62636363 62636363 and round 10 key = b4ef5bcb 3e92e211 23e951cf 6f8f188e.

Source files
------------

// File: rtl/key_expansion.sv
// AES-128 on-the-fly key schedule: holds the current round key and steps to the
// next one in a single cycle on each next_in strobe, up to round 10.
module key_expansion #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] key_0_in,
  input  logic [DATA_WIDTH-1:0] key_1_in,
  input  logic [DATA_WIDTH-1:0] key_2_in,
  input  logic [DATA_WIDTH-1:0] key_3_in,
  input  logic                  key_load_in,
  input  logic                  next_in,
  output logic [DATA_WIDTH-1:0] key_0_out,
  output logic [DATA_WIDTH-1:0] key_1_out,
  output logic [DATA_WIDTH-1:0] key_2_out,
  output logic [DATA_WIDTH-1:0] key_3_out,
  output logic [3:0]            round_out,
  output logic                  key_valid_out,
  output logic                  key_last_out
);

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [DATA_WIDTH-1:0] w0_q, w1_q, w2_q, w3_q;
  logic [3:0]            round_q;
  logic                  valid_q;
  logic                  last_q;

  logic [DATA_WIDTH-1:0] rot, sub, t;
  logic [DATA_WIDTH-1:0] w0_n, w1_n, w2_n, w3_n;
  logic [7:0]            rcon;
  logic                  advance;

  // Rcon for the round being produced (round_q + 1)
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    rot  = {w3_q[23:0], w3_q[31:24]};
    sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    t    = sub ^ {rcon, 24'h0};
    w0_n = w0_q ^ t;
    w1_n = w1_q ^ w0_n;
    w2_n = w2_q ^ w1_n;
    w3_n = w3_q ^ w2_n;
  end

  assign advance = next_in && valid_q && (round_q < LAST_ROUND);

  // Load wins over next_in when both strobes coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (key_load_in) begin
      w0_q    <= key_0_in;
      w1_q    <= key_1_in;
      w2_q    <= key_2_in;
      w3_q    <= key_3_in;
      round_q <= 4'd0;
      valid_q <= 1'b1;
      last_q  <= 1'b0;
    end else if (advance) begin
      w0_q    <= w0_n;
      w1_q    <= w1_n;
      w2_q    <= w2_n;
      w3_q    <= w3_n;
      round_q <= round_q + 4'd1;
      last_q  <= (round_q == LAST_ROUND - 4'd1);
    end
  end

  assign key_0_out     = w0_q;
  assign key_1_out     = w1_q;
  assign key_2_out     = w2_q;
  assign key_3_out     = w3_q;
  assign round_out     = round_q;
  assign key_valid_out = valid_q;
  assign key_last_out  = last_q;

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboarded bench for key_expansion: reference key schedule derived from
// GF(2^8) arithmetic, directed FIPS-197 vectors plus randomized strobes/resets.
module tb_key_expansion;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] key_0_in, key_1_in, key_2_in, key_3_in;
  logic        key_load_in, next_in;
  logic [31:0] key_0_out, key_1_out, key_2_out, key_3_out;
  logic [3:0]  round_out;
  logic        key_valid_out, key_last_out;

  key_expansion #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_0_in(key_0_in), .key_1_in(key_1_in), .key_2_in(key_2_in), .key_3_in(key_3_in),
    .key_load_in(key_load_in), .next_in(next_in),
    .key_0_out(key_0_out), .key_1_out(key_1_out), .key_2_out(key_2_out), .key_3_out(key_3_out),
    .round_out(round_out), .key_valid_out(key_valid_out), .key_last_out(key_last_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [135:0] exp_q[$];
  logic [7:0]   sbm [256];
  logic [31:0]  mk [4];
  logic [3:0]   mround;
  logic         mvalid;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine transform
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbm[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand();
    logic [7:0]  rc;
    logic [31:0] r, t;
    rc = 8'h01;
    for (int i = 1; i <= int'(mround); i++) rc = gmul(rc, 8'h02);
    r = {mk[3][23:0], mk[3][31:24]};
    t = {sbm[r[31:24]], sbm[r[23:16]], sbm[r[15:8]], sbm[r[7:0]]} ^ {rc, 24'h0};
    mk[0] = mk[0] ^ t;
    mk[1] = mk[1] ^ mk[0];
    mk[2] = mk[2] ^ mk[1];
    mk[3] = mk[3] ^ mk[2];
    mround = mround + 4'd1;
  endtask

  function automatic logic [135:0] model_vec();
    return {mk[0], mk[1], mk[2], mk[3], mround, mvalid, (mvalid && mround == 4'd10), 2'b00};
  endfunction

  function automatic logic [135:0] dut_vec();
    return {key_0_out, key_1_out, key_2_out, key_3_out, round_out, key_valid_out, key_last_out, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mk[i] = 32'h0;
    mround = 4'd0;
    mvalid = 1'b0;
  endtask

  task automatic step(input logic ld, input logic nx,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    key_load_in = ld; next_in = nx;
    key_0_in = a; key_1_in = b; key_2_in = c; key_3_in = d;
    if (ld) begin
      mk[0] = a; mk[1] = b; mk[2] = c; mk[3] = d;
      mround = 4'd0;
      mvalid = 1'b1;
    end else if (nx && mvalid && mround < 4'd10) begin
      model_expand();
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic nxt();
    step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Async reset pulse strictly between clock edges, checked before the next edge
  task automatic reset_pulse(input string name);
    @(negedge clk);
    key_load_in = 1'b0; next_in = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #2 chk(name, dut_vec(), 136'h0);
    #1 rst_n = 1'b1;
    exp_q.push_back(model_vec());
  endtask

  task automatic chk_now(input string name, input logic [127:0] k,
                         input logic [3:0] rnd, input logic last);
    @(posedge clk);
    #2 chk(name, dut_vec(), {k, rnd, 1'b1, last, 2'b00});
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [135:0] e;
      e = exp_q.pop_front();
      chk("scoreboard", dut_vec(), e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  initial begin
    logic [127:0] fk, nk;
    fk = FIPS_KEY;
    rst_n = 1'b0;
    key_load_in = 1'b0; next_in = 1'b0;
    key_0_in = '0; key_1_in = '0; key_2_in = '0; key_3_in = '0;
    model_reset();
    build_sbox();
    #3 chk("reset_state", dut_vec(), 136'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // next_in without a prior load is ignored
    repeat (3) nxt();
    @(posedge clk);
    #2 chk("no_load_next", dut_vec(), 136'h0);

    step(1'b1, 1'b0, fk[127:96], fk[95:64], fk[63:32], fk[31:0]);
    nxt();
    chk_now("fips_round1", FIPS_R1, 4'd1, 1'b0);
    repeat (9) nxt();
    chk_now("fips_round10", FIPS_R10, 4'd10, 1'b1);
    nxt();
    chk_now("fips_11th_next", FIPS_R10, 4'd10, 1'b1);
    idle();

    // load + next together at round 5
    step(1'b1, 1'b0, fk[127:96], fk[95:64], fk[63:32], fk[31:0]);
    repeat (5) nxt();
    nk = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b1, nk[127:96], nk[95:64], nk[63:32], nk[31:0]);
    chk_now("load_wins_over_next", nk, 4'd0, 1'b0);

    // reset at round 7, then reload reproduces the schedule
    step(1'b1, 1'b0, fk[127:96], fk[95:64], fk[63:32], fk[31:0]);
    repeat (7) nxt();
    reset_pulse("reset_mid_expansion");
    nxt();
    @(posedge clk);
    #2 chk("post_reset_next_ignored", dut_vec(), 136'h0);
    step(1'b1, 1'b0, fk[127:96], fk[95:64], fk[63:32], fk[31:0]);
    repeat (10) nxt();
    chk_now("reload_round10", FIPS_R10, 4'd10, 1'b1);

    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    nxt();
    chk_now("zero_round1", ZERO_R1, 4'd1, 1'b0);
    repeat (9) nxt();
    chk_now("zero_round10", ZERO_R10, 4'd10, 1'b1);

    // randomized strobes with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0)
        reset_pulse("random_reset");
      else
        step(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
             $urandom, $urandom, $urandom, $urandom);
    end
    idle();
    idle();
    repeat (3) @(posedge clk);
    #3 chk("scoreboard_drained", 136'(exp_q.size()), 136'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
